// File: rtl/tanh_arbiter_pkg.sv
// Shared constants for the tanh arbiter: Q4.20 fixed-point anchors and the
// default datapath width.
package tanh_arbiter_pkg;

    localparam int DEF_WIDTH = 24;

    // Q4.20 anchors (0x100000 = 1.0)
    localparam int ONE     = 32'h0010_0000;
    localparam int HALF    = 32'h0008_0000;
    localparam int QUARTER = 32'h0004_0000;
    localparam int SAT_THR = 32'h0020_0000;
    localparam int NEG_ONE = 32'h00F0_0000;

endpackage

// File: rtl/tanh_arbiter_pwl.sv
// tanh_pwl: combinational four-segment piecewise-linear tanh in Q4.20.
// Segment constants take the sign of the input; shifts are arithmetic and the
// final add wraps at WIDTH bits.
module tanh_pwl
    import tanh_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] x_i,
    output logic [WIDTH-1:0] y_o
);

    localparam logic signed [WIDTH-1:0] C_ONE  = WIDTH'(ONE);
    localparam logic signed [WIDTH-1:0] C_HALF = WIDTH'(HALF);
    localparam logic signed [WIDTH-1:0] C_QTR  = WIDTH'(QUARTER);
    localparam logic signed [WIDTH-1:0] C_SAT  = WIDTH'(SAT_THR);

    function automatic logic signed [WIDTH-1:0] tanh_eval(input logic signed [WIDTH-1:0] x);
        logic neg;
        neg = x[WIDTH-1];
        if (x >= C_SAT || x <= -C_SAT) begin
            return neg ? -C_ONE : C_ONE;
        end else if (x >= C_ONE || x <= -C_ONE) begin
            return (x >>> 2) + (neg ? -C_HALF : C_HALF);
        end else if (x >= C_HALF || x <= -C_HALF) begin
            return (x >>> 1) + (neg ? -C_QTR : C_QTR);
        end else begin
            return x;
        end
    endfunction

    // Evaluate the transfer function
    always_comb begin
        y_o = tanh_eval($signed(x_i));
    end

endmodule

// File: rtl/tanh_arbiter.sv
// tanh_arbiter: round-robin arbiter feeding a two-stage tanh pipeline.
// Optional build macro TANH_ARB_STATS_EN adds the stat_busy occupancy counter.
module tanh_arbiter
    import tanh_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_REQ = 4,
    parameter int ID_W  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [ID_W-1:0]        out_id
`ifdef TANH_ARB_STATS_EN
    ,
    output logic [15:0]            stat_busy
`endif
);

    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             found;
    int               idx;
    logic             s1_load;
    logic             s2_load;
    logic             accept;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] pwl_y;
    logic [ID_W-1:0]  ptr_q, ptr_d;

    logic             vld_p1_q;
    logic [WIDTH-1:0] data_p1_q;
    logic [ID_W-1:0]  id_p1_q;
    logic             vld_p2_q;
    logic [WIDTH-1:0] data_p2_q;
    logic [ID_W-1:0]  id_p2_q;

    // Round-robin search starting at the pointer, wrapping at N_REQ-1
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr_q) + i) % N_REQ;
            if (!found && req_valid[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = ID_W'(idx);
                found    = 1'b1;
            end
        end
    end

    // S2 frees up when empty or draining; S1 when it empties or moves into S2.
    // req_ready is held low while in reset so nothing is granted into a clearing pipe.
    assign s2_load   = !vld_p2_q || out_ready;
    assign s1_load   = s2_load || !vld_p1_q;
    assign req_ready = (rst_n && s1_load) ? gnt : '0;
    assign accept    = |req_ready;
    assign sel_data  = req_data[int'(gnt_id)*WIDTH +: WIDTH];

    // Pointer moves past the winner only on a completed handshake
    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (gnt_id == ID_W'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
        end
    end

    tanh_pwl #(.WIDTH(WIDTH)) u_pwl (
        .x_i (data_p1_q),
        .y_o (pwl_y)
    );

    // Pipeline registers: S1 captures the granted operand, S2 the tanh result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            vld_p1_q  <= 1'b0;
            data_p1_q <= '0;
            id_p1_q   <= '0;
            vld_p2_q  <= 1'b0;
            data_p2_q <= '0;
            id_p2_q   <= '0;
        end else begin
            ptr_q <= ptr_d;
            // ---- stage S1 ----
            if (s1_load) begin
                vld_p1_q <= accept;
                if (accept) begin
                    data_p1_q <= sel_data;
                    id_p1_q   <= gnt_id;
                end
            end
            // ---- stage S2 ----
            if (s2_load) begin
                vld_p2_q <= vld_p1_q;
                if (vld_p1_q) begin
                    data_p2_q <= pwl_y;
                    id_p2_q   <= id_p1_q;
                end
            end
        end
    end

    assign out_valid = vld_p2_q;
    assign out_data  = data_p2_q;
    assign out_id    = id_p2_q;

`ifdef TANH_ARB_STATS_EN
    logic [15:0] stat_q;

    // Count cycles with a valid result in S2, saturating at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= '0;
        end else if (vld_p2_q && stat_q != 16'hFFFF) begin
            stat_q <= stat_q + 16'd1;
        end
    end

    assign stat_busy = stat_q;
`endif

endmodule
